reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   Architectural register file with rename tags: the commit-side receiver of the reorder buffer.
//   Holds x0..x31 values and, per register, the ROB entry (tag) that will produce its next value.
//   Supplies operands (value or pending tag) to the issuer.
//   Retires ROB commits into the value array; on ROB flush, drops every pending tag.
// PARAMETERS
//   REG_WIDTH     32  data width of one architectural register
//   REG_ID_WIDTH  5   register index width (32 registers)
//   ROB_ID_WIDTH  4   ROB tag width; tag 0 = "no producer", valid tags 1..2^ROB_ID_WIDTH-1
// PORTS
//   clk                 in   1             clock; all state updates on posedge
//   rst                 in   1             synchronous, active-high reset
//   rdy                 in   1             global enable; when 0 no state changes
//   reset_from_rob_bus  in   1             ROB mispredict flush, one-cycle pulse
//   dest_from_rob       in   ROB_ID_WIDTH  committing ROB entry; 0 = no commit this cycle
//   rd_from_rob         in   REG_ID_WIDTH  destination register of commit
//   value_from_rob      in   REG_WIDTH     committed result
//   valid_from_issuer   in   1             issuer allocates a destination this cycle
//   rd_from_issuer      in   REG_ID_WIDTH  destination register being renamed
//   dest_from_issuer    in   ROB_ID_WIDTH  ROB tag assigned to that destination
//   rs1_from_issuer     in   REG_ID_WIDTH  source-1 index
//   rs2_from_issuer     in   REG_ID_WIDTH  source-2 index
//   vj_to_issuer        out  REG_WIDTH     source-1 value (valid when qj_to_issuer==0)
//   qj_to_issuer        out  ROB_ID_WIDTH  source-1 pending tag, 0 = value ready
//   vk_to_issuer        out  REG_WIDTH     source-2 value (valid when qk_to_issuer==0)
//   qk_to_issuer        out  ROB_ID_WIDTH  source-2 pending tag, 0 = value ready
// BEHAVIOUR
//   State: value[0..31], tag[0..31]; value[0] and tag[0] are constant 0.
//   Reset (rst=1 at posedge): all values and tags <= 0, regardless of rdy.
//     Outputs are combinational; after reset every read gives v=0, q=0.
//   rdy=0: arrays hold; read outputs stay combinationally valid.
//   Commit (rdy, dest_from_rob!=0, rd_from_rob!=0):
//     value[rd] <= value_from_rob.
//     tag[rd] <= 0 only if tag[rd]==dest_from_rob; a younger rename stays.
//     rd_from_rob==0 (branch/store/x0 commits): no effect.
//   Issue (rdy, valid_from_issuer, rd_from_issuer!=0, no flush): tag[rd] <= dest_from_issuer.
//   Same-cycle commit and issue to the same rd: value written from commit; issue tag wins.
//   Flush (rdy, reset_from_rob_bus=1):
//     - Every tag <= 0.
//     - A commit in the same cycle still writes its value; flush and commit arrive together from the ROB.
//     - An issue in the same cycle is ignored.
//   Read path (rs1 -> vj/qj; rs2 -> vk/qk, identical), combinational, 0-cycle latency:
//     - rs==0: v=0, q=0.
//     - tag[rs]==0: v=value[rs], q=0.
//     - Bypass: tag[rs]!=0, dest_from_rob==tag[rs], rd_from_rob==rs: v=value_from_rob, q=0.
//     - Otherwise: v=0, q=tag[rs].
//   Reads see the mapping before this cycle's issue write.
//     "add x5,x5,x1" reads the old producer of x5, not its own tag.
//   Tags are never compared for age; the ROB guarantees a tag is not reused while still mapped.
// TESTING
//   1. Reset then read rs1=3, rs2=0 -> vj=0, qj=0, vk=0, qk=0; writes to rd=0 never change x0.
//   2. Issue rd=5 tag=2; next cycle rs1=5 -> qj=2.
//      Commit dest=2 rd=5 value=0x1234 -> same-cycle read vj=0x1234, qj=0; next cycle tag[5]=0.
//   3. Issue rd=7 tag=3, then rd=7 tag=4; commit dest=3 value=0xAA -> value[7]=0xAA, qj stays 4.
//      Commit dest=4 value=0xBB -> qj=0, vj=0xBB.
//   4. Same cycle: commit dest=6 rd=9 val=0x55 and issue rd=9 tag=8 -> value[9]=0x55, tag[9]=8.
//      rs1=9 same cycle -> forwarded 0x55.
//   5. Tags pending on x1,x2,x3; flush with commit dest=1 rd=4 val=0x77, plus issue rd=10 tag=5.
//      -> all q=0; value[4]=0x77; tag[10]=0; x1..x3 keep old values.
//   6. rdy=0 with commit and issue asserted -> no array change.
//      rst=1 while tags pending and rdy=0 -> all cleared next cycle.

Source files
------------

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Retires ROB commits, renames issuer destinations and supplies operands with same-cycle commit bypass.
module reg_file #(
   parameter int REG_WIDTH    = 32,
   parameter int REG_ID_WIDTH = 5,
   parameter int ROB_ID_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    reset_from_rob_bus,
   input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
   input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
   input  logic [REG_WIDTH-1:0]    value_from_rob,
   input  logic                    valid_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
   input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
   output logic [REG_WIDTH-1:0]    vj_to_issuer,
   output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
   output logic [REG_WIDTH-1:0]    vk_to_issuer,
   output logic [ROB_ID_WIDTH-1:0] qk_to_issuer
);

   localparam int NUM_REGS = 1 << REG_ID_WIDTH;
   localparam logic [ROB_ID_WIDTH-1:0] NO_TAG   = {ROB_ID_WIDTH{1'b0}};
   localparam logic [REG_ID_WIDTH-1:0] X0       = {REG_ID_WIDTH{1'b0}};
   localparam logic [REG_WIDTH-1:0]    ZERO_VAL = {REG_WIDTH{1'b0}};

   logic [REG_WIDTH-1:0]    value_r [NUM_REGS];
   logic [ROB_ID_WIDTH-1:0] tag_r   [NUM_REGS];
   logic                    commit_s;
   logic                    issue_s;

   // Qualify commit and issue requests; x0 is never a destination
   always_comb begin
      commit_s = (dest_from_rob != NO_TAG) && (rd_from_rob != X0);
      issue_s  = valid_from_issuer && (rd_from_issuer != X0) && !reset_from_rob_bus;
   end

   // Value and tag array update: reset, commit retirement, rename and flush
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_r[i] <= ZERO_VAL;
            tag_r[i]   <= NO_TAG;
         end
      end else if (rdy) begin
         if (commit_s) begin
            value_r[rd_from_rob] <= value_from_rob;
         end
         if (reset_from_rob_bus) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               tag_r[i] <= NO_TAG;
            end
         end else begin
            // Only clear the mapping if no younger rename has replaced it
            if (commit_s && (tag_r[rd_from_rob] == dest_from_rob)) begin
               tag_r[rd_from_rob] <= NO_TAG;
            end
            // Issued later in the block so a same-cycle rename wins over the clear
            if (issue_s) begin
               tag_r[rd_from_issuer] <= dest_from_issuer;
            end
         end
      end
   end

   // Source-1 operand read with commit bypass
   always_comb begin
      vj_to_issuer = ZERO_VAL;
      qj_to_issuer = NO_TAG;
      if (rs1_from_issuer == X0) begin
         vj_to_issuer = ZERO_VAL;
         qj_to_issuer = NO_TAG;
      end else if (tag_r[rs1_from_issuer] == NO_TAG) begin
         vj_to_issuer = value_r[rs1_from_issuer];
         qj_to_issuer = NO_TAG;
      end else if ((dest_from_rob == tag_r[rs1_from_issuer]) && (rd_from_rob == rs1_from_issuer)) begin
         vj_to_issuer = value_from_rob;
         qj_to_issuer = NO_TAG;
      end else begin
         vj_to_issuer = ZERO_VAL;
         qj_to_issuer = tag_r[rs1_from_issuer];
      end
   end

   // Source-2 operand read with commit bypass
   always_comb begin
      vk_to_issuer = ZERO_VAL;
      qk_to_issuer = NO_TAG;
      if (rs2_from_issuer == X0) begin
         vk_to_issuer = ZERO_VAL;
         qk_to_issuer = NO_TAG;
      end else if (tag_r[rs2_from_issuer] == NO_TAG) begin
         vk_to_issuer = value_r[rs2_from_issuer];
         qk_to_issuer = NO_TAG;
      end else if ((dest_from_rob == tag_r[rs2_from_issuer]) && (rd_from_rob == rs2_from_issuer)) begin
         vk_to_issuer = value_from_rob;
         qk_to_issuer = NO_TAG;
      end else begin
         vk_to_issuer = ZERO_VAL;
         qk_to_issuer = tag_r[rs2_from_issuer];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        reset_from_rob_bus;
   logic [3:0]  dest_from_rob;
   logic [4:0]  rd_from_rob;
   logic [31:0] value_from_rob;
   logic        valid_from_issuer;
   logic [4:0]  rd_from_issuer;
   logic [3:0]  dest_from_issuer;
   logic [4:0]  rs1_from_issuer;
   logic [4:0]  rs2_from_issuer;
   logic [31:0] vj_to_issuer;
   logic [3:0]  qj_to_issuer;
   logic [31:0] vk_to_issuer;
   logic [3:0]  qk_to_issuer;

   int chk_n  = 0;
   int fail_n = 0;

   logic [31:0] m_val [32];
   logic [3:0]  m_tag [32];

   reg_file dut (
      .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
      .dest_from_rob(dest_from_rob), .rd_from_rob(rd_from_rob), .value_from_rob(value_from_rob),
      .valid_from_issuer(valid_from_issuer), .rd_from_issuer(rd_from_issuer),
      .dest_from_issuer(dest_from_issuer), .rs1_from_issuer(rs1_from_issuer),
      .rs2_from_issuer(rs2_from_issuer), .vj_to_issuer(vj_to_issuer), .qj_to_issuer(qj_to_issuer),
      .vk_to_issuer(vk_to_issuer), .qk_to_issuer(qk_to_issuer)
   );

   always #5 clk = ~clk;

   // Operand an issuer should see for register rs given model state and current ROB inputs
   function automatic void model_read(input logic [4:0] rs, output logic [31:0] v, output logic [3:0] q);
      if (rs == 5'd0) begin
         v = 32'd0; q = 4'd0;
      end else if (m_tag[rs] == 4'd0) begin
         v = m_val[rs]; q = 4'd0;
      end else if (dest_from_rob == m_tag[rs] && rd_from_rob == rs) begin
         v = value_from_rob; q = 4'd0;
      end else begin
         v = 32'd0; q = m_tag[rs];
      end
   endfunction

   // One clock: compute the model's next state from the current inputs, then advance
   task automatic tick();
      logic [31:0] nv [32];
      logic [3:0]  nt [32];
      for (int i = 0; i < 32; i++) begin
         nv[i] = m_val[i];
         nt[i] = m_tag[i];
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            nv[i] = 32'd0; nt[i] = 4'd0;
         end
      end else if (rdy) begin
         if (dest_from_rob != 4'd0 && rd_from_rob != 5'd0) begin
            nv[rd_from_rob] = value_from_rob;
            if (m_tag[rd_from_rob] == dest_from_rob) nt[rd_from_rob] = 4'd0;
         end
         if (valid_from_issuer && rd_from_issuer != 5'd0) nt[rd_from_issuer] = dest_from_issuer;
         if (reset_from_rob_bus) begin
            for (int i = 0; i < 32; i++) nt[i] = 4'd0;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         m_val[i] = nv[i];
         m_tag[i] = nt[i];
      end
   endtask

   task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
      rst = 1'b0; rdy = 1'b1; reset_from_rob_bus = 1'b0;
      dest_from_rob = 4'd0; rd_from_rob = 5'd0; value_from_rob = 32'd0;
      valid_from_issuer = 1'b0; rd_from_issuer = 5'd0; dest_from_issuer = 4'd0;
      rs1_from_issuer = rs1; rs2_from_issuer = rs2;
   endtask

   task automatic commit(input logic [3:0] d, input logic [4:0] rd, input logic [31:0] v);
      dest_from_rob = d; rd_from_rob = rd; value_from_rob = v;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [3:0] d);
      valid_from_issuer = 1'b1; rd_from_issuer = rd; dest_from_issuer = d;
   endtask

   task automatic test_reset();
      idle(5'd0, 5'd0);
      rst = 1'b1;
      tick(); tick();
      idle(5'd3, 5'd0);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'd0 || qj_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL reset_read vj=%h qj=%0d vk=%h qk=%0d expected all 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
      commit(4'd1, 5'd0, 32'hFFFF_FFFF);
      issue(5'd0, 4'd5);
      tick();
      idle(5'd0, 5'd0);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'd0 || qj_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL x0_write vj=%h qj=%0d expected 0 0", vj_to_issuer, qj_to_issuer);
      end
   endtask

   task automatic test_rename_commit();
      idle(5'd0, 5'd0);
      issue(5'd5, 4'd2);
      tick();
      idle(5'd5, 5'd0);
      #1;
      chk_n++;
      if (qj_to_issuer !== 4'd2 || vj_to_issuer !== 32'd0) begin
         fail_n++;
         $display("FAIL rename_tag qj=%0d vj=%h expected qj=2 vj=0", qj_to_issuer, vj_to_issuer);
      end
      commit(4'd2, 5'd5, 32'h1234);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'h1234 || qj_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL commit_bypass vj=%h qj=%0d expected 1234 0", vj_to_issuer, qj_to_issuer);
      end
      tick();
      idle(5'd0, 5'd5);
      #1;
      chk_n++;
      if (vk_to_issuer !== 32'h1234 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL commit_retire vk=%h qk=%0d expected 1234 0", vk_to_issuer, qk_to_issuer);
      end
   endtask

   task automatic test_younger_rename();
      idle(5'd0, 5'd0);
      issue(5'd7, 4'd3);
      tick();
      idle(5'd0, 5'd0);
      issue(5'd7, 4'd4);
      tick();
      idle(5'd7, 5'd0);
      commit(4'd3, 5'd7, 32'hAA);
      #1;
      chk_n++;
      if (qj_to_issuer !== 4'd4 || vj_to_issuer !== 32'd0) begin
         fail_n++;
         $display("FAIL old_commit_nobypass qj=%0d vj=%h expected 4 0", qj_to_issuer, vj_to_issuer);
      end
      tick();
      idle(5'd7, 5'd0);
      #1;
      chk_n++;
      if (qj_to_issuer !== 4'd4) begin
         fail_n++;
         $display("FAIL younger_tag_kept qj=%0d expected 4", qj_to_issuer);
      end
      commit(4'd4, 5'd7, 32'hBB);
      tick();
      idle(5'd7, 5'd0);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'hBB || qj_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL younger_commit vj=%h qj=%0d expected bb 0", vj_to_issuer, qj_to_issuer);
      end
   endtask

   task automatic test_same_cycle();
      idle(5'd0, 5'd0);
      issue(5'd9, 4'd6);
      tick();
      idle(5'd9, 5'd0);
      commit(4'd6, 5'd9, 32'h55);
      issue(5'd9, 4'd8);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'h55 || qj_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL same_cycle_bypass vj=%h qj=%0d expected 55 0", vj_to_issuer, qj_to_issuer);
      end
      tick();
      idle(5'd9, 5'd0);
      #1;
      chk_n++;
      if (qj_to_issuer !== 4'd8) begin
         fail_n++;
         $display("FAIL issue_tag_wins qj=%0d expected 8", qj_to_issuer);
      end
   endtask

   task automatic test_flush();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         idle(5'd0, 5'd0);
         commit(4'd15, 5'(i + 1), vals[i]);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         idle(5'd0, 5'd0);
         issue(5'(i + 1), 4'(i + 1));
         tick();
      end
      idle(5'd0, 5'd0);
      reset_from_rob_bus = 1'b1;
      commit(4'd1, 5'd4, 32'h77);
      issue(5'd10, 4'd5);
      tick();
      idle(5'd1, 5'd2);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'h11 || qj_to_issuer !== 4'd0 || vk_to_issuer !== 32'h22 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL flush_x1_x2 vj=%h qj=%0d vk=%h qk=%0d expected 11 0 22 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
      idle(5'd3, 5'd4);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'h33 || qj_to_issuer !== 4'd0 || vk_to_issuer !== 32'h77 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL flush_x3_commit vj=%h qj=%0d vk=%h qk=%0d expected 33 0 77 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
      idle(5'd10, 5'd9);
      #1;
      chk_n++;
      if (qj_to_issuer !== 4'd0 || vj_to_issuer !== 32'd0 || vk_to_issuer !== 32'h55 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL flush_issue_drop vj=%h qj=%0d vk=%h qk=%0d expected 0 0 55 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
   endtask

   task automatic test_rdy_hold();
      idle(5'd7, 5'd0);
      rdy = 1'b0;
      commit(4'd2, 5'd12, 32'h99);
      issue(5'd13, 4'd6);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'hBB || qj_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL rdy0_read vj=%h qj=%0d expected bb 0", vj_to_issuer, qj_to_issuer);
      end
      tick();
      idle(5'd12, 5'd13);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'd0 || qj_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL rdy0_hold vj=%h qj=%0d vk=%h qk=%0d expected all 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
      issue(5'd14, 4'd7);
      tick();
      idle(5'd0, 5'd0);
      rdy = 1'b0;
      rst = 1'b1;
      tick();
      idle(5'd14, 5'd5);
      #1;
      chk_n++;
      if (vj_to_issuer !== 32'd0 || qj_to_issuer !== 4'd0 || vk_to_issuer !== 32'd0 || qk_to_issuer !== 4'd0) begin
         fail_n++;
         $display("FAIL rst_over_rdy vj=%h qj=%0d vk=%h qk=%0d expected all 0", vj_to_issuer, qj_to_issuer, vk_to_issuer, qk_to_issuer);
      end
   endtask

   task automatic test_random();
      logic [31:0] ev;
      logic [3:0]  eq;
      for (int n = 0; n < 600; n++) begin
         idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         rst = ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 7) != 0);
         reset_from_rob_bus = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 1) begin
            rd_from_rob = ($urandom_range(0, 1) == 1) ? rs1_from_issuer : 5'($urandom_range(0, 31));
            dest_from_rob = ($urandom_range(0, 1) == 1) ? m_tag[rd_from_rob] : 4'($urandom_range(1, 15));
            value_from_rob = $urandom;
         end
         if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)));
         #1;
         model_read(rs1_from_issuer, ev, eq);
         chk_n++;
         if (vj_to_issuer !== ev || qj_to_issuer !== eq) begin
            fail_n++;
            $display("FAIL rand_rs1 n=%0d rs=%0d vj=%h qj=%0d expected %h %0d", n, rs1_from_issuer, vj_to_issuer, qj_to_issuer, ev, eq);
         end
         model_read(rs2_from_issuer, ev, eq);
         chk_n++;
         if (vk_to_issuer !== ev || qk_to_issuer !== eq) begin
            fail_n++;
            $display("FAIL rand_rs2 n=%0d rs=%0d vk=%h qk=%0d expected %h %0d", n, rs2_from_issuer, vk_to_issuer, qk_to_issuer, ev, eq);
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_val[i] = 32'd0;
         m_tag[i] = 4'd0;
      end
      idle(5'd0, 5'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_rename_commit();
      test_younger_rename();
      test_same_cycle();
      test_flush();
      test_rdy_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", chk_n, fail_n);
      $finish;
   end

endmodule
